// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain bitstream loader.
package ccff_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_VERIFY,
      ST_DONE
   } ccff_state_e;

   function automatic int cnt_width(input int chain_len);
      return $clog2(chain_len + 1);
   endfunction

   function automatic int words_per_pass(input int chain_len, input int word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

   localparam int DEF_CHAIN_LEN      = 8;
   localparam int DEF_WORD_W         = 8;
   localparam int DEF_CNT_W          = cnt_width(DEF_CHAIN_LEN);
   localparam int DEF_WORDS_PER_PASS = words_per_pass(DEF_CHAIN_LEN, DEF_WORD_W);

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word holding buffer feeding a shift register; emits one bit per cycle,
// LSB first, with a registered bit and bit-valid (chain shift enable).
module ccff_word_serializer #(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              active,
   input  logic              pass_end,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              bit_out,
   output logic              bit_en
);

   localparam int SC_W = $clog2(WORD_W + 1);
   localparam logic [SC_W-1:0] WORD_REM = SC_W'(WORD_W - 1);

   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] hold;
   logic [SC_W-1:0]   rem;
   logic              hold_full;
   logic              hs;

   assign bs_ready = active & ~hold_full;
   assign hs       = bs_valid & bs_ready;

   // Next bit priority: shift register, then held word, then the word arriving
   // this cycle, so an accepted word can drive its bit 0 in the very next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg     <= '0;
         hold      <= '0;
         rem       <= '0;
         hold_full <= 1'b0;
         bit_out   <= 1'b0;
         bit_en    <= 1'b0;
      end else if (!active) begin
         rem       <= '0;
         hold_full <= 1'b0;
         bit_en    <= 1'b0;
      end else begin
         bit_en <= 1'b0;
         if (pass_end) begin
            // leftover bits of the pass's last word are dropped here
            rem <= '0;
            if (hs) begin
               hold      <= bs_data;
               hold_full <= 1'b1;
            end
         end else if (rem != '0) begin
            bit_out <= shreg[0];
            shreg   <= shreg >> 1;
            rem     <= rem - SC_W'(1);
            bit_en  <= 1'b1;
            if (hs) begin
               hold      <= bs_data;
               hold_full <= 1'b1;
            end
         end else if (hold_full) begin
            bit_out   <= hold[0];
            shreg     <= hold >> 1;
            rem       <= WORD_REM;
            hold_full <= 1'b0;
            bit_en    <= 1'b1;
         end else if (hs) begin
            bit_out <= bs_data[0];
            shreg   <= bs_data >> 1;
            rem     <= WORD_REM;
            bit_en  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Loads a configuration chain from host bitstream words, with an optional
// second pass that checks the chain tail against the re-sent bitstream.
module ccff_bitstream_loader
   import ccff_pkg::*;
#(
   parameter int CHAIN_LEN = 8,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              verify_en,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              verify_err
);

   localparam int CNT_W = cnt_width(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

   ccff_state_e      state;
   logic             verify_q;
   logic [CNT_W-1:0] bit_cnt;
   logic             shifting;
   logic             pass_end;

   assign shifting = (state == ST_LOAD) || (state == ST_VERIFY);
   assign pass_end = shifting && ccff_shift_en && (bit_cnt == LAST_BIT);

   ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
      .clk      (prog_clk),
      .rst      (pReset),
      .active   (shifting),
      .pass_end (pass_end),
      .bs_data  (bs_data),
      .bs_valid (bs_valid),
      .bs_ready (bs_ready),
      .bit_out  (ccff_head),
      .bit_en   (ccff_shift_en)
   );

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state      <= ST_IDLE;
         verify_q   <= 1'b0;
         bit_cnt    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         verify_err <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_LOAD;
                  verify_q   <= verify_en;
                  verify_err <= 1'b0;
                  bit_cnt    <= '0;
                  busy       <= 1'b1;
               end
            end
            ST_LOAD, ST_VERIFY: begin
               if (ccff_shift_en) begin
                  // tail now carries the pass-1 bit at the index being driven
                  if (state == ST_VERIFY && ccff_tail != ccff_head)
                     verify_err <= 1'b1;
                  if (pass_end) begin
                     bit_cnt <= '0;
                     if (state == ST_LOAD && verify_q) begin
                        state <= ST_VERIFY;
                     end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench: an 8-bit chain with a behavioural flop model, plus a
// 20-bit chain for multi-word, truncation and stall sequences.
module tb_ccff_bitstream_loader;

   logic prog_clk = 1'b0;
   logic pReset   = 1'b1;
   always #5 prog_clk = ~prog_clk;

   logic       start8 = 0, verify8 = 0, valid8 = 0, ready8, head8, sh8, tail8, busy8, done8, err8;
   logic [7:0] data8 = '0;
   logic       start20 = 0, verify20 = 0, valid20 = 0, ready20, head20, sh20, busy20, done20, err20;
   logic       tail20 = 1'b0;
   logic [7:0] data20 = '0;

   logic [7:0] chain8;
   logic       flip_req = 1'b0;

   int checks = 0;
   int failures = 0;

   ccff_bitstream_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
      .prog_clk(prog_clk), .pReset(pReset), .start(start8), .verify_en(verify8),
      .bs_data(data8), .bs_valid(valid8), .bs_ready(ready8), .ccff_head(head8),
      .ccff_shift_en(sh8), .ccff_tail(tail8), .busy(busy8), .done(done8),
      .verify_err(err8));

   ccff_bitstream_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut20 (
      .prog_clk(prog_clk), .pReset(pReset), .start(start20), .verify_en(verify20),
      .bs_data(data20), .bs_valid(valid20), .bs_ready(ready20), .ccff_head(head20),
      .ccff_shift_en(sh20), .ccff_tail(tail20), .busy(busy20), .done(done20),
      .verify_err(err20));

   // Behavioural 8-flop chain; flip_req corrupts one flop on a non-shift cycle.
   always @(posedge prog_clk) begin
      if (sh8) chain8 <= {chain8[6:0], head8};
      else if (flip_req) chain8[3] <= ~chain8[3];
   end
   assign tail8 = chain8[7];

   typedef struct {
      logic       verify;
      logic [7:0] word;
      logic       flip;
      int         p1;
      int         p2;
      logic [7:0] exp_seq;   // MSB = first bit on ccff_head
      logic       exp_err;
   } vec_t;

   vec_t tbl[7];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic run8(input vec_t v, input int id);
      int n;
      int exp_n;
      logic [15:0] seq;
      bit seen_done;
      bit flipped;
      n = 0; seq = '0; seen_done = 0; flipped = 0;
      exp_n = v.verify ? 16 : 8;
      data8 = v.word; valid8 = 1; verify8 = v.verify; start8 = 1;
      @(negedge prog_clk);
      start8 = 0;
      check($sformatf("v%0d_busy", id), 32'(busy8), 32'd1);
      for (int c = 0; c < 120 && !seen_done; c++) begin
         start8 = 0; verify8 = v.verify; flip_req = 0;
         if (sh8) begin
            if (n < 16) seq[15-n] = head8;
            n++;
            if (n == v.p1 || n == v.p2) begin
               start8 = 1; verify8 = ~v.verify;
            end
         end else if (v.flip && n == 8 && !flipped) begin
            flip_req = 1; flipped = 1;
         end
         if (done8) begin
            seen_done = 1;
            check($sformatf("v%0d_ready_in_done", id), 32'(ready8), 32'd0);
         end else begin
            @(negedge prog_clk);
         end
      end
      start8 = 0; flip_req = 0; valid8 = 0;
      check($sformatf("v%0d_done_seen", id), 32'(seen_done), 32'd1);
      check($sformatf("v%0d_shift_count", id), 32'(n), 32'(exp_n));
      check($sformatf("v%0d_pass1_bits", id), 32'(seq[15:8]), 32'(v.exp_seq));
      if (v.verify) check($sformatf("v%0d_pass2_bits", id), 32'(seq[7:0]), 32'(v.exp_seq));
      @(negedge prog_clk);
      check($sformatf("v%0d_idle_busy_done", id), 32'({busy8, done8}), 32'd0);
      check($sformatf("v%0d_verify_err", id), 32'(err8), 32'(v.exp_err));
   endtask

   task automatic run20(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                        input bit stall, input logic [19:0] exp_seq, input string tag);
      int n;
      int idx;
      int stall_n;
      bit hs_pend;
      bit seen_done;
      logic last_head;
      logic [19:0] seq;
      n = 0; idx = 0; stall_n = 0; hs_pend = 0; seen_done = 0; last_head = 0; seq = '0;
      verify20 = 0; start20 = 1;
      @(negedge prog_clk);
      start20 = 0;
      for (int c = 0; c < 200 && !seen_done; c++) begin
         if (hs_pend) idx++;
         if (idx >= 3 || (stall && idx == 1 && stall_n < 5)) begin
            valid20 = 0;
         end else begin
            valid20 = 1;
            data20 = (idx == 0) ? w0 : (idx == 1) ? w1 : w2;
         end
         if (stall && idx == 1 && n == 8 && stall_n < 5) begin
            check($sformatf("%s_stall_shift_en", tag), 32'(sh20), 32'd0);
            check($sformatf("%s_stall_head", tag), 32'(head20), 32'(last_head));
            stall_n++;
         end
         if (sh20) begin
            if (n < 20) seq[19-n] = head20;
            n++;
            last_head = head20;
         end
         hs_pend = valid20 && ready20;
         if (done20) seen_done = 1;
         else @(negedge prog_clk);
      end
      valid20 = 0;
      check($sformatf("%s_done_seen", tag), 32'(seen_done), 32'd1);
      check($sformatf("%s_shift_count", tag), 32'(n), 32'd20);
      check($sformatf("%s_bits", tag), 32'(seq), 32'(exp_seq));
      check($sformatf("%s_words_taken", tag), 32'(idx), 32'd3);
      if (stall) check($sformatf("%s_stall_cycles", tag), 32'(stall_n), 32'd5);
      @(negedge prog_clk);
      check($sformatf("%s_idle_busy", tag), 32'(busy20), 32'd0);
   endtask

   initial begin
      int n;
      int bad;
      vec_t v_after;

      tbl[0] = '{verify: 1'b0, word: 8'hA5, flip: 1'b0, p1: 0, p2: 0, exp_seq: 8'b10100101, exp_err: 1'b0};
      tbl[1] = '{verify: 1'b0, word: 8'h1E, flip: 1'b0, p1: 0, p2: 0, exp_seq: 8'b01111000, exp_err: 1'b0};
      tbl[2] = '{verify: 1'b1, word: 8'hC3, flip: 1'b0, p1: 0, p2: 0, exp_seq: 8'b11000011, exp_err: 1'b0};
      tbl[3] = '{verify: 1'b1, word: 8'hC3, flip: 1'b1, p1: 0, p2: 0, exp_seq: 8'b11000011, exp_err: 1'b1};
      tbl[4] = '{verify: 1'b0, word: 8'h80, flip: 1'b0, p1: 0, p2: 0, exp_seq: 8'b00000001, exp_err: 1'b0};
      tbl[5] = '{verify: 1'b1, word: 8'h1E, flip: 1'b0, p1: 0, p2: 0, exp_seq: 8'b01111000, exp_err: 1'b0};
      tbl[6] = '{verify: 1'b1, word: 8'hC3, flip: 1'b1, p1: 3, p2: 14, exp_seq: 8'b11000011, exp_err: 1'b1};

      pReset = 1;
      repeat (3) @(negedge prog_clk);
      check("reset_outputs8", 32'({ready8, head8, sh8, busy8, done8, err8}), 32'd0);
      check("reset_outputs20", 32'({ready20, head20, sh20, busy20, done20, err20}), 32'd0);
      pReset = 0;
      @(negedge prog_clk);

      for (int i = 0; i < 7; i++) run8(tbl[i], i);

      run20(8'h0F, 8'hF0, 8'h3C, 1'b0, 20'b11110000000011110011, "multi");
      run20(8'hD5, 8'hAA, 8'h07, 1'b1, 20'b10101011010101011110, "stall");

      // Reset while bit 3 of a load is on the chain head
      data8 = 8'hFF; valid8 = 1; verify8 = 0; start8 = 1;
      @(negedge prog_clk);
      start8 = 0;
      n = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         if (sh8) n++;
         if (n < 4) @(negedge prog_clk);
      end
      check("rst_reached_bit3", 32'(n), 32'd4);
      pReset = 1;
      @(negedge prog_clk);
      check("rst_mid_outputs", 32'({ready8, head8, sh8, busy8, done8, err8}), 32'd0);
      pReset = 0;
      bad = 0;
      repeat (12) begin
         @(negedge prog_clk);
         if (done8 || busy8 || sh8) bad++;
      end
      check("rst_no_done_after", 32'(bad), 32'd0);
      valid8 = 0;
      v_after = '{verify: 1'b0, word: 8'h5A, flip: 1'b0, p1: 0, p2: 0, exp_seq: 8'b01011010, exp_err: 1'b0};
      run8(v_after, 7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
